// File: rtl/toy_ram_master_pkg.sv
// Shared encodings and the load-extension helper for the toy RAM initiator.
package toy_ram_master_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic [31:0] load_extend(
        input logic [31:0] raw,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: res = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/toy_ram_master_fmt.sv
// Combinational datapath: store merge (new low lanes over read data) and load extension.
module toy_ram_master_fmt
    import toy_ram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] merge_data,
    output logic [DATA_WIDTH-1:0] load_data
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [LANES-1:0] lane_sel;

    always_comb begin
        lane_sel = '1;
        case (size)
            SZ_BYTE: lane_sel = LANES'(1);
            SZ_HALF: lane_sel = LANES'(3);
            default: lane_sel = '1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merge_data[gi*8 +: 8] = lane_sel[gi] ? wdata[gi*8 +: 8] : rdata[gi*8 +: 8];
        end
    endgenerate

    assign load_data = load_extend(rdata, size, is_unsigned);

endmodule

// File: rtl/toy_ram_master.sv
// Toy RAM initiator: one CPU load/store at a time, sub-word stores as read-modify-write,
// per-phase timeout and conflict abort.
module toy_ram_master
    import toy_ram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_available,
    input  logic                  mem_conflict_err
);

    // Abort fires on the cycle the wait count would reach TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] fmt_merge;
    logic [DATA_WIDTH-1:0] fmt_load;

    toy_ram_master_fmt #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fmt (
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .merge_data  (fmt_merge),
        .load_data   (fmt_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    // Word stores write the request data directly; merge_q doubles as the write buffer.
                    merge_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (req_size == SZ_ILLEGAL) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (req_we && req_size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                if (mem_conflict_err) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_available) begin
                    cnt_d = '0;
                    if (we_q) begin
                        merge_d = fmt_merge;
                        state_d = ST_WR;
                    end else begin
                        rdata_d = fmt_load;
                        state_d = ST_RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_WR: begin
                if (mem_conflict_err) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_available) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_read   = (state_q == ST_RD);
    assign mem_write  = (state_q == ST_WR);
    assign mem_addr   = (mem_read || mem_write) ? addr_q : '0;
    assign mem_wdata  = mem_write ? merge_q : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: doc/toy_ram_master.md
Name: toy_ram_master

Overview:
- Initiator end of the toy RAM port: turns CPU load/store requests into RAM read/write transactions and returns load data.
- RAM writes always cover 4 bytes starting at the byte address. Byte and halfword stores are therefore done as read-modify-write.
- Sits between the execute stage and the toy RAM. Handles one request at a time, with a timeout and error reporting.

Parameters:
- DATA_WIDTH, 32, CPU/RAM data width; only 32 is supported.
- ADDR_WIDTH, 16, byte address width.
- TIMEOUT, 255, maximum cycles to wait for mem_available per RAM phase before aborting; must be 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block idle, accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; only the low bytes selected by size are used.
- resp_valid  out  1  one-cycle pulse: request finished.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: illegal size, RAM conflict, or timeout.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_WIDTH  RAM byte address.
- mem_wdata  out  DATA_WIDTH  to RAM dat_in.
- mem_rdata  in  DATA_WIDTH  from RAM dat_out.
- mem_available  in  1  RAM phase complete / data valid.
- mem_conflict_err  in  1  RAM conflict indication.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except req_ready = 1. Internal registers cleared. Any in-flight RAM phase is dropped.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready = 1. On req_valid, register addr/we/size/unsigned/wdata and clear the timeout counter.
  - size == 3: go to RESP with err = 1.
  - store of size 2: go to WR.
  - otherwise: go to RD.
- RD: mem_read = 1, mem_addr = latched addr.
  - On mem_available: capture mem_rdata.
  - If load: go to RESP with rdata = extend(captured, size).
  - If store: build merge = {captured[31:8], wdata[7:0]} for byte, or {captured[31:16], wdata[15:0]} for half; go to WR.
- WR: mem_write = 1, mem_addr = latched addr, mem_wdata = wdata for word stores, merge otherwise. Held stable for the whole phase.
  - On mem_available: go to RESP with err = 0.
- Timeout: in RD/WR the 8-bit counter increments every cycle mem_available is low and resets on entry to each phase. If it reaches TIMEOUT while mem_available is low: go to RESP with err = 1, rdata = 0.
- Conflict: mem_conflict_err high during RD/WR aborts to RESP with err = 1. It takes priority over mem_available in the same cycle.
- RESP: resp_valid = 1 for exactly one cycle with registered rdata/err, then IDLE. req_ready = 0 during RESP. A new request is accepted the cycle after RESP.
- mem_read and mem_write are never both 1. Both are 0 outside RD/WR, as are mem_addr and mem_wdata.
- Latency with zero-wait RAM (mem_available the same cycle as the strobe), accept to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Address arithmetic: no alignment requirement. The address is passed unchanged; wrap-around at the top of memory is the RAM's concern.
- Extension: byte uses bit 7, half uses bit 15, word is passed through.
- req_valid while not ready is ignored; the requester must hold it.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding;
  - the function for load extension by size and unsigned.
- Natural sub-module: toy_ram_master_fmt, a combinational merge/extend datapath (store merge, load extension). The FSM and timeout counter stay in the top.

Test Plan:
- Word load, addr 0x0010, RAM returns 0x8000_00F0 after 2 wait cycles -> mem_read high for 3 cycles, resp_rdata = 0x8000_00F0, err = 0.
- Signed byte load, RAM data 0x1234_5680 -> resp_rdata = 0xFFFF_FF80. Same load with unsigned -> 0x0000_0080.
- Half store wdata 0xAAAA_BEEF, RAM holds 0x1122_3344 at addr -> read phase, then write phase with mem_wdata = 0x1122_BEEF; resp after 3 cycles (zero wait).
- mem_available held low, TIMEOUT = 4 -> abort after 4 cycles, resp_err = 1, resp_rdata = 0, strobes drop.
- req_size = 3 -> no RAM strobe, resp_err = 1 one cycle after accept. Separately, mem_conflict_err and mem_available asserted together -> err = 1.
- rst asserted mid-WR -> mem_write drops immediately, req_ready = 1, no resp_valid. The next request completes normally.
